// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// The datapath drives hazard inputs; the controller returns stall, bubble and flush controls.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic [4:0]  ex_rd_i;
  logic        ex_memread_i;
  logic        ex_branch_taken_i;
  logic        ex_mc_req_i;
  logic        ex_mc_done_i;
  logic        mem_stall_req_i;
  logic        cnt_clr_i;
  logic [5:0]  stall_o;
  logic        bubble_ex_o;
  logic        bubble_mem_o;
  logic        bubble_wb_o;
  logic        flush_o;
  logic        mc_timeout_o;
  logic        state_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, ex_rd_i, ex_memread_i,
           ex_branch_taken_i, ex_mc_req_i, ex_mc_done_i, mem_stall_req_i, cnt_clr_i,
    input  stall_o, bubble_ex_o, bubble_mem_o, bubble_wb_o, flush_o, mc_timeout_o,
           state_o, stall_cycles_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, ex_rd_i, ex_memread_i,
           ex_branch_taken_i, ex_mc_req_i, ex_mc_done_i, mem_stall_req_i, cnt_clr_i,
    output stall_o, bubble_ex_o, bubble_mem_o, bubble_wb_o, flush_o, mc_timeout_o,
           state_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use, multi-cycle EX wait with timeout,
// memory stall and branch flush, plus a saturating count of PC-stall cycles.
module pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT = 40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, MCWAIT = 1'b1} state_e;

  localparam logic [7:0] TMO_LIM = 8'(MC_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  stall_s;
  logic        bubble_ex_s, bubble_mem_s, bubble_wb_s, flush_s, tmo_s;
  logic        lu_s, mcs_s, tmo_hit_s;

  assign lu_s = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                ((bus.id_rs1_re_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                 (bus.id_rs2_re_i && (bus.id_rs2_i == bus.ex_rd_i)));

  assign mcs_s = ((state_q == RUN) && bus.ex_mc_req_i) ||
                 ((state_q == MCWAIT) && !bus.ex_mc_done_i);

  // Done in the same cycle as the limit wins, so the abort only fires without done.
  assign tmo_hit_s = (state_q == MCWAIT) && !bus.ex_mc_done_i &&
                     ((tmo_cnt_q + 8'd1) == TMO_LIM);

  // Prioritised stall/bubble/flush decode, forced quiet while reset is held.
  always_comb begin
    stall_s      = 6'b000000;
    bubble_ex_s  = 1'b0;
    bubble_mem_s = 1'b0;
    bubble_wb_s  = 1'b0;
    flush_s      = 1'b0;
    tmo_s        = 1'b0;
    if (!rst_i) begin
      stall_s = 6'b000000;
    end else if (bus.mem_stall_req_i) begin
      stall_s     = 6'b011111;
      bubble_wb_s = 1'b1;
      tmo_s       = tmo_hit_s;
    end else if (mcs_s) begin
      stall_s      = 6'b001111;
      bubble_mem_s = 1'b1;
      tmo_s        = tmo_hit_s;
    end else if (bus.ex_branch_taken_i) begin
      flush_s = 1'b1;
    end else if (lu_s) begin
      stall_s     = 6'b000111;
      bubble_ex_s = 1'b1;
    end else begin
      stall_s = 6'b000000;
    end
  end

  // Next-state for the multi-cycle FSM, its timeout counter and the stall counter.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (bus.ex_mc_req_i && !bus.mem_stall_req_i) begin
          state_d   = MCWAIT;
          tmo_cnt_d = 8'd1;
        end else begin
          state_d   = RUN;
          tmo_cnt_d = 8'd0;
        end
      end
      MCWAIT: begin
        if (bus.ex_mc_done_i || tmo_hit_s) begin
          state_d   = RUN;
          tmo_cnt_d = 8'd0;
        end else begin
          state_d   = MCWAIT;
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = RUN;
        tmo_cnt_d = 8'd0;
      end
    endcase
    if (bus.cnt_clr_i) begin
      stall_cnt_d = 32'd0;
    end else if (stall_s[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      tmo_cnt_q   <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_o        = stall_s;
  assign bus.bubble_ex_o    = bubble_ex_s;
  assign bus.bubble_mem_o   = bubble_mem_s;
  assign bus.bubble_wb_o    = bubble_wb_s;
  assign bus.flush_o        = flush_s;
  assign bus.mc_timeout_o   = tmo_s;
  assign bus.state_o        = (state_q == MCWAIT);
  assign bus.stall_cycles_o = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter: MC_TIMEOUT, default 40, maximum MCWAIT cycles before abort (legal range 2..255).
REQ-002 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: id_rs1_i, id_rs2_i  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports: id_rs1_re_i, id_rs2_re_i  input  1 each  read enables from the decoder.
REQ-006 SHALL have port: ex_rd_i  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port: ex_memread_i  input  1  the instruction in EX is a load.
REQ-008 SHALL have port: ex_branch_taken_i  input  1  the instruction in EX redirects the PC.
REQ-009 SHALL have ports: ex_mc_req_i, ex_mc_done_i  input  1 each  multi-cycle EX operation start / result ready.
REQ-010 SHALL have port: mem_stall_req_i  input  1  data memory not ready.
REQ-011 SHALL have port: cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-012 SHALL have port: stall_o  output  6  hold per stage, bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-013 SHALL have ports: bubble_ex_o, bubble_mem_o, bubble_wb_o  output  1 each  insert NOP into ID/EX, EX/MEM, MEM/WB.
REQ-014 SHALL have port: flush_o  output  1  clear IF/ID and ID/EX.
REQ-015 SHALL have port: mc_timeout_o  output  1  one-cycle abort pulse.
REQ-016 SHALL have ports: state_o  output  1  (0 RUN, 1 MCWAIT); stall_cycles_o  output  32  stall count.

Function
REQ-017 stall_o, bubble_*_o, flush_o SHALL be combinational from current state and inputs (zero latency); state, timeout counter, stall counter SHALL be registered.
REQ-018 Load-use hazard LU SHALL equal ex_memread_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
REQ-019 MC stall MCS SHALL equal (state RUN & ex_mc_req_i) | (state MCWAIT & !ex_mc_done_i).
REQ-020 Priority SHALL be mem stall > MCS > flush > LU > none; exactly one row applies per cycle:
  - mem_stall_req_i: stall_o=6'b011111, bubble_wb_o=1, flush_o=0.
  - MCS: stall_o=6'b001111, bubble_mem_o=1, flush_o=0.
  - ex_branch_taken_i: stall_o=0, flush_o=1, no bubble (LU ignored).
  - LU: stall_o=6'b000111, bubble_ex_o=1.
  - none: all zero.
REQ-021 FSM RUN->MCWAIT SHALL occur when ex_mc_req_i=1 and mem_stall_req_i=0; timeout counter loads 1.
REQ-022 In MCWAIT, ex_mc_done_i=1 SHALL return to RUN next cycle; that cycle MCS=0 so EX advances.
REQ-023 In MCWAIT without done, counter SHALL increment each cycle (including mem-stalled cycles); when it equals MC_TIMEOUT, mc_timeout_o=1 that cycle, stall_o per REQ-020 still applies, next state RUN, counter 0.
REQ-024 ex_mc_done_i and timeout in the same cycle SHALL be treated as done (mc_timeout_o=0).
REQ-025 ex_mc_req_i in MCWAIT SHALL be ignored; ex_mc_done_i in RUN SHALL be ignored.
REQ-026 stall_cycles_o SHALL increment on each cycle with stall_o[0]=1, saturate at 32'hFFFFFFFF, and cnt_clr_i SHALL win over increment (next value 0).
REQ-027 ex_rd_i==0 SHALL never produce LU.

Reset
REQ-028 While rst_i=0: state RUN, timeout counter 0, stall_cycles_o 0, stall_o 0, all bubbles 0, flush_o 0, mc_timeout_o 0, regardless of other inputs.
REQ-029 Reset asserted in MCWAIT SHALL abort immediately without mc_timeout_o pulse; first cycle after release is RUN.

Verification
REQ-030 Load x5 in EX (ex_memread_i=1, ex_rd_i=5), ID reads rs1=5 re=1 -> stall_o=6'b000111, bubble_ex_o=1; same with rs1_re=0 -> all zero.
REQ-031 LU plus ex_branch_taken_i=1 -> flush_o=1, stall_o=0, bubble_ex_o=0; add mem_stall_req_i=1 -> stall_o=6'b011111, flush_o=0.
REQ-032 ex_mc_req_i pulse, done 4 cycles later -> stall_o=6'b001111 for 4 cycles, state_o=1 for 4 cycles, 0 on done cycle+1, stall_cycles_o=4.
REQ-033 MC_TIMEOUT=40, ex_mc_req_i, no done -> mc_timeout_o single pulse on 40th stall cycle, state_o=0 next cycle.
REQ-034 Preload stall_cycles_o near saturation via 2^32 stall cycles (or force) -> holds 32'hFFFFFFFF; cnt_clr_i with stall -> 0.
REQ-035 rst_i low mid-MCWAIT -> all outputs 0 asynchronously, no mc_timeout_o, RUN after release.
